// File: rtl/systolic_scheduler.sv
// systolic_scheduler: sequences weight/input BRAM reads into a systolic MAC array.
// Ports: clk, rst (sync, active-high); start/clear_all/cfg_len run control;
//   weight_bram_* and input_bram_* read ports (one-cycle latency);
//   mac_w_data/mac_x_data (pass-through), mac_valid, mac_clear to the array;
//   busy, done, perf_cycles status.
// Optional: define SCHED_PERF_CNT_EN to build the busy-cycle counter behind perf_cycles.
module systolic_scheduler #(
    parameter int N_MACS = 4,
    parameter int LEN_W  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear_all,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             weight_bram_en,
    output logic [10:0]      weight_bram_addr,
    input  logic [63:0]      weight_bram_dout,
    output logic             input_bram_en,
    output logic [LEN_W-1:0] input_bram_addr,
    input  logic [15:0]      input_bram_dout,
    output logic [63:0]      mac_w_data,
    output logic [15:0]      mac_x_data,
    output logic             mac_valid,
    output logic             mac_clear,
    output logic             busy,
    output logic             done,
    output logic [15:0]      perf_cycles
);
    localparam int D_W = $clog2(N_MACS + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, FIN} state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] step;
    logic [D_W-1:0]   dcnt;
    logic             en;
    logic             abort;
    logic             fin;

    assign weight_bram_en   = en;
    assign input_bram_en    = en;
    assign weight_bram_addr = 11'(step);
    assign input_bram_addr  = step;
    assign mac_w_data       = weight_bram_dout;
    assign mac_x_data       = input_bram_dout;

    // busy mirrors CLEAR/STREAM/DRAIN, so it doubles as the "abortable" flag
    assign abort = clear_all && busy;
    // last busy cycle of a run that completes normally
    assign fin   = !clear_all && ((state == CLEAR && len == '0) ||
                                  (state == DRAIN && dcnt == D_W'(N_MACS - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            step      <= '0;
            dcnt      <= '0;
            en        <= 1'b0;
            mac_valid <= 1'b0;
            mac_clear <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            en        <= 1'b0;
            mac_valid <= 1'b0;
            mac_clear <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // read data arrives one cycle after the enable
            mac_valid <= en;
            mac_clear <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_all) begin
                        mac_clear <= 1'b1;
                    end else if (start) begin
                        len       <= cfg_len;
                        state     <= CLEAR;
                        mac_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (fin) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= STREAM;
                        en    <= 1'b1;
                        step  <= '0;
                    end
                end
                STREAM: begin
                    if (step == len - LEN_W'(1)) begin
                        state <= DRAIN;
                        en    <= 1'b0;
                        dcnt  <= '0;
                    end else begin
                        step <= step + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (fin) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + D_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [15:0] cnt;
    logic [15:0] cnt_inc;

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // cnt restarts whenever idle; perf_cycles only updates on a completed run
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            perf_cycles <= '0;
        end else begin
            cnt <= busy ? cnt_inc : '0;
            if (fin) perf_cycles <= cnt_inc;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule
